// File: rtl/ram_test_master_pkg.sv
// Shared definitions for the RAM self-test master.
// Holds bus widths, FSM state encoding, failure codes, the default pattern
// key and the pattern function.
// Optional feature macro: RAM_TEST_CLEAR_EN (adds the clear-phase states).
package ram_test_master_pkg;

  localparam int unsigned ADR_W = 21;
  localparam int unsigned DAT_W = 16;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned FC_W  = 2;

  localparam logic [FC_W-1:0] FC_NONE     = 2'b00;
  localparam logic [FC_W-1:0] FC_MISMATCH = 2'b01;
  localparam logic [FC_W-1:0] FC_TIMEOUT  = 2'b10;

  localparam logic [DAT_W-1:0] PAT_KEY_DEF = 16'o125252;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_WR_REQ,
    ST_WR_GAP,
    ST_RD_REQ,
    ST_RD_GAP,
`ifdef RAM_TEST_CLEAR_EN
    ST_CLR_REQ,
    ST_CLR_GAP,
`endif
    ST_DONE,
    ST_FAIL
  } state_t;

  // Test pattern: low 16 word-address bits XOR key; upper address bits never enter.
  function automatic logic [DAT_W-1:0] pat(input logic [DAT_W-1:0] a,
                                           input logic [DAT_W-1:0] key);
    return a ^ key;
  endfunction

endpackage

// File: rtl/ram_test_master_if.sv
// Word-memory bus between the test master (requester) and the RAM responder.
// Signals: stb, we, sel, adr (word address [21:1]), out (write data) from the
// master; dat (read data), ack, ready from the responder.
interface ram_test_master_if;

  logic                                  stb;
  logic                                  we;
  logic [ram_test_master_pkg::SEL_W-1:0] sel;
  logic [ram_test_master_pkg::ADR_W-1:0] adr;
  logic [ram_test_master_pkg::DAT_W-1:0] out;
  logic [ram_test_master_pkg::DAT_W-1:0] dat;
  logic                                  ack;
  logic                                  ready;

  modport master (output stb, we, sel, adr, out, input dat, ack, ready);
  modport slave  (input stb, we, sel, adr, out, output dat, ack, ready);

endinterface

// File: rtl/ram_test_timeout.sv
// Loadable down-counter with expiry flag for bus-transaction watchdogs.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   load      - reload the counter with load_val (takes priority over dec)
//   dec       - count one waiting cycle
//   load_val  - reload value (the allowed number of waiting cycles)
//   expire_c  - combinational: this dec exhausts the budget
module ram_test_timeout #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         expire_c
);

  logic [W-1:0] cnt;

  // Expiry fires on the decrement that would take the count from 1 to 0.
  assign expire_c = dec && (cnt == W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/ram_test_master.sv
// Power-up self-test bus master for main memory: writes an address-derived
// pattern to words 0..ADR_LAST, reads it back and verifies it, and optionally
// zero-fills memory afterwards. Processor is held off while busy is high.
// Optional feature macro: RAM_TEST_CLEAR_EN (enables the clear phase).
// Ports:
//   clk_p, reset           - clock, synchronous active-high reset
//   start                  - one-cycle pulse, honoured only when idle
//   busy, done, fail       - status; done/fail held until next start/reset
//   fail_code/adr/dat      - reason, word address and read data of first failure
//   mem                    - word-memory bus, master side
module ram_test_master
  import ram_test_master_pkg::*;
#(
  parameter logic [ADR_W-1:0] ADR_LAST = 21'h007FFF,
  parameter int unsigned      TIMEOUT  = 16,
  parameter logic [DAT_W-1:0] PAT_KEY  = PAT_KEY_DEF
) (
  input  logic              clk_p,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [FC_W-1:0]   fail_code,
  output logic [ADR_W-1:0]  fail_adr,
  output logic [DAT_W-1:0]  fail_dat,
  ram_test_master_if.master mem
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [ADR_W-1:0] addr;
  logic [ADR_W-1:0] addr_nxt;
  logic             addr_last;
  logic [DAT_W-1:0] exp_dat;
  logic             tmo_expire_c;

  assign mem.sel   = 2'b11;
  assign addr_nxt  = addr + ADR_W'(1);
  assign addr_last = (addr == ADR_LAST);
  assign exp_dat   = pat(addr[DAT_W-1:0], PAT_KEY);

  // Every REQ is entered from a cycle with stb low, so reloading while stb is
  // low restarts the budget on each request; only unacked stb cycles count.
  ram_test_timeout #(.W(TMO_W)) u_tmo (
    .clk      (clk_p),
    .rst      (reset),
    .load     (~mem.stb),
    .dec      (mem.stb & ~mem.ack),
    .load_val (TMO_W'(TIMEOUT)),
    .expire_c (tmo_expire_c)
  );

  // Test sequencer: address counter, bus drive, compare and status.
  always_ff @(posedge clk_p) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= FC_NONE;
      fail_adr  <= '0;
      fail_dat  <= '0;
      mem.stb   <= 1'b0;
      mem.we    <= 1'b0;
      mem.adr   <= '0;
      mem.out   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_WAIT_RDY;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= FC_NONE;
            fail_adr  <= '0;
            fail_dat  <= '0;
          end
        end

        ST_WAIT_RDY: begin
          if (mem.ready) begin
            state   <= ST_WR_REQ;
            addr    <= '0;
            mem.stb <= 1'b1;
            mem.we  <= 1'b1;
            mem.adr <= '0;
            mem.out <= pat('0, PAT_KEY);
          end
        end

        ST_WR_REQ: begin
          if (mem.ack) begin
            state   <= ST_WR_GAP;
            mem.stb <= 1'b0;
          end else if (tmo_expire_c) begin
            state     <= ST_FAIL;
            mem.stb   <= 1'b0;
            fail_code <= FC_TIMEOUT;
            fail_adr  <= addr;
            fail_dat  <= '0;
          end
        end

        ST_WR_GAP: begin
          mem.stb <= 1'b1;
          if (addr_last) begin
            state   <= ST_RD_REQ;
            addr    <= '0;
            mem.we  <= 1'b0;
            mem.adr <= '0;
            mem.out <= '0;
          end else begin
            state   <= ST_WR_REQ;
            addr    <= addr_nxt;
            mem.we  <= 1'b1;
            mem.adr <= addr_nxt;
            mem.out <= pat(addr_nxt[DAT_W-1:0], PAT_KEY);
          end
        end

        ST_RD_REQ: begin
          if (mem.ack) begin
            mem.stb <= 1'b0;
            if (mem.dat != exp_dat) begin
              state     <= ST_FAIL;
              fail_code <= FC_MISMATCH;
              fail_adr  <= addr;
              fail_dat  <= mem.dat;
            end else begin
              state <= ST_RD_GAP;
            end
          end else if (tmo_expire_c) begin
            state     <= ST_FAIL;
            mem.stb   <= 1'b0;
            fail_code <= FC_TIMEOUT;
            fail_adr  <= addr;
            fail_dat  <= '0;
          end
        end

        ST_RD_GAP: begin
          if (addr_last) begin
`ifdef RAM_TEST_CLEAR_EN
            state   <= ST_CLR_REQ;
            addr    <= '0;
            mem.stb <= 1'b1;
            mem.we  <= 1'b1;
            mem.adr <= '0;
            mem.out <= '0;
`else
            state <= ST_DONE;
`endif
          end else begin
            state   <= ST_RD_REQ;
            addr    <= addr_nxt;
            mem.stb <= 1'b1;
            mem.we  <= 1'b0;
            mem.adr <= addr_nxt;
          end
        end

`ifdef RAM_TEST_CLEAR_EN
        ST_CLR_REQ: begin
          if (mem.ack) begin
            state   <= ST_CLR_GAP;
            mem.stb <= 1'b0;
          end else if (tmo_expire_c) begin
            state     <= ST_FAIL;
            mem.stb   <= 1'b0;
            fail_code <= FC_TIMEOUT;
            fail_adr  <= addr;
            fail_dat  <= '0;
          end
        end

        ST_CLR_GAP: begin
          if (addr_last) begin
            state <= ST_DONE;
          end else begin
            state   <= ST_CLR_REQ;
            addr    <= addr_nxt;
            mem.stb <= 1'b1;
            mem.we  <= 1'b1;
            mem.adr <= addr_nxt;
            mem.out <= '0;
          end
        end
`endif

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        ST_FAIL: begin
          state   <= ST_IDLE;
          mem.stb <= 1'b0;
          busy    <= 1'b0;
          fail    <= 1'b1;
        end

        default: begin
          state   <= ST_IDLE;
          mem.stb <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_test_master.sv
// Directed bench for ram_test_master with ADR_LAST=7, TIMEOUT=16 against a
// 64K-word RAM responder that acks on the third strobe cycle.
module tb_ram_test_master;
  import ram_test_master_pkg::*;

  localparam logic [ADR_W-1:0] T_ADR_LAST = 21'd7;
  localparam int unsigned      T_TIMEOUT  = 16;
  localparam int               WORDS      = 8;
  localparam logic [15:0]      KEY        = 16'o125252;
`ifdef RAM_TEST_CLEAR_EN
  localparam int PHASES = 3;
`else
  localparam int PHASES = 2;
`endif
  localparam int EXP_BUSY   = 4 * WORDS * PHASES + 2;
  localparam int EXP_WRITES = WORDS * (PHASES - 1);

  logic             clk_p = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             busy, done, fail;
  logic [1:0]       fail_code;
  logic [20:0]      fail_adr;
  logic [15:0]      fail_dat;

  ram_test_master_if mem_if ();

  ram_test_master #(
    .ADR_LAST (T_ADR_LAST),
    .TIMEOUT  (T_TIMEOUT),
    .PAT_KEY  (KEY)
  ) dut (
    .clk_p     (clk_p),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_code (fail_code),
    .fail_adr  (fail_adr),
    .fail_dat  (fail_dat),
    .mem       (mem_if)
  );

  always #5 clk_p = ~clk_p;

  // RAM responder model
  logic [15:0] ram [0:65535];
  logic        resp_ack = 1'b0;
  logic [15:0] rd_dat = 16'h0;
  int          wcnt = 0;
  int          corrupt_rd_adr = -1;
  int          noack_wr_adr = -1;
  bit          stray_en = 1'b0;
  bit          ready = 1'b1;
  int          wlog_adr [$];
  int          wlog_dat [$];

  assign mem_if.ack   = resp_ack | (stray_en & ~mem_if.stb);
  assign mem_if.dat   = rd_dat;
  assign mem_if.ready = ready;

  always @(posedge clk_p) begin
    resp_ack <= 1'b0;
    if (!mem_if.stb) begin
      wcnt <= 0;
    end else if (!resp_ack) begin
      if (wcnt < 1) begin
        wcnt <= wcnt + 1;
      end else if (mem_if.we) begin
        if (int'(mem_if.adr) != noack_wr_adr) begin
          resp_ack <= 1'b1;
          wcnt     <= 0;
          ram[mem_if.adr[15:0]] <= mem_if.out;
          wlog_adr.push_back(int'(mem_if.adr));
          wlog_dat.push_back(int'(mem_if.out));
        end
      end else begin
        resp_ack <= 1'b1;
        wcnt     <= 0;
        rd_dat   <= (int'(mem_if.adr) == corrupt_rd_adr) ? 16'h0 : ram[mem_if.adr[15:0]];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int rd_hi_seen = 0;
  int stb3_cycles = 0;
  int stb_cycles = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and update the bus monitors.
  task automatic tick();
    @(negedge clk_p);
    if (mem_if.stb && !mem_if.we && mem_if.adr >= 21'd6) rd_hi_seen++;
    if (mem_if.stb && mem_if.we && mem_if.adr == 21'd3) stb3_cycles++;
    if (mem_if.stb) stb_cycles++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts busy cycles from the first cycle after the start edge.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 4000) begin
      n++;
      tick();
    end
    check_eq("busy_drops", 32'(busy), 32'd0);
  endtask

  task automatic check_pass(input string tag, input int wbase, input bit chk_busy, input int nb);
    if (chk_busy) check_eq({tag, "_busy_cycles"}, 32'(nb), 32'(EXP_BUSY));
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_fail"}, 32'(fail), 32'd0);
    check_eq({tag, "_fail_code"}, 32'(fail_code), 32'd0);
    check_eq({tag, "_nwrites"}, 32'(wlog_adr.size() - wbase), 32'(EXP_WRITES));
    for (int i = 0; i < WORDS; i++) begin
      if (wbase + i < wlog_adr.size()) begin
        check_eq($sformatf("%s_wr_adr%0d", tag, i), 32'(wlog_adr[wbase + i]), 32'(i));
        check_eq($sformatf("%s_wr_dat%0d", tag, i), 32'(wlog_dat[wbase + i]), 32'(KEY ^ 16'(i)));
      end
    end
    for (int i = 0; i < WORDS; i++) begin
`ifdef RAM_TEST_CLEAR_EN
      check_eq($sformatf("%s_ram%0d", tag, i), 32'(ram[i]), 32'd0);
`else
      check_eq($sformatf("%s_ram%0d", tag, i), 32'(ram[i]), 32'(KEY ^ 16'(i)));
`endif
    end
  endtask

  initial begin
    int nb;
    int wbase;
    bit found;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_fail", 32'(fail), 32'd0);
    check_eq("rst_fail_code", 32'(fail_code), 32'd0);
    check_eq("rst_fail_adr", 32'(fail_adr), 32'd0);
    check_eq("rst_stb", 32'(mem_if.stb), 32'd0);
    check_eq("rst_sel", 32'(mem_if.sel), 32'd3);

    // Normal pass
    wbase = wlog_adr.size();
    pulse_start();
    check_eq("pass_busy_rise", 32'(busy), 32'd1);
    wait_idle(nb);
    check_pass("pass", wbase, 1'b1, nb);
    tick(); tick();
    check_eq("pass_done_held", 32'(done), 32'd1);

    // Read-back mismatch at address 5
    corrupt_rd_adr = 5;
    rd_hi_seen = 0;
    pulse_start();
    check_eq("mm_done_cleared", 32'(done), 32'd0);
    wait_idle(nb);
    check_eq("mm_fail", 32'(fail), 32'd1);
    check_eq("mm_done", 32'(done), 32'd0);
    check_eq("mm_fail_code", 32'(fail_code), 32'd1);
    check_eq("mm_fail_adr", 32'(fail_adr), 32'd5);
    check_eq("mm_fail_dat", 32'(fail_dat), 32'd0);
    check_eq("mm_no_rd_6_7", 32'(rd_hi_seen), 32'd0);
    check_eq("mm_stb_low", 32'(mem_if.stb), 32'd0);
    corrupt_rd_adr = -1;

    // Write of address 3 never acked
    noack_wr_adr = 3;
    stb3_cycles = 0;
    pulse_start();
    check_eq("to_fail_cleared", 32'(fail), 32'd0);
    wait_idle(nb);
    check_eq("to_stb_cycles", 32'(stb3_cycles), 32'd16);
    check_eq("to_fail", 32'(fail), 32'd1);
    check_eq("to_fail_code", 32'(fail_code), 32'd2);
    check_eq("to_fail_adr", 32'(fail_adr), 32'd3);
    check_eq("to_fail_dat", 32'(fail_dat), 32'd0);
    check_eq("to_busy", 32'(busy), 32'd0);
    noack_wr_adr = -1;

    // Reset during the read of address 4
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (mem_if.stb && !mem_if.we && mem_if.adr == 21'd4) found = 1'b1;
      else tick();
    end
    check_eq("rr_found_rd4", 32'(found), 32'd1);
    reset = 1'b1;
    tick();
    check_eq("rr_stb", 32'(mem_if.stb), 32'd0);
    check_eq("rr_busy", 32'(busy), 32'd0);
    check_eq("rr_done", 32'(done), 32'd0);
    check_eq("rr_fail", 32'(fail), 32'd0);
    reset = 1'b0;
    tick(); tick();
    wbase = wlog_adr.size();
    pulse_start();
    wait_idle(nb);
    check_pass("rr_restart", wbase, 1'b1, nb);

    // Responder not ready for 50 cycles after start
    ready = 1'b0;
    wbase = wlog_adr.size();
    pulse_start();
    stb_cycles = 0;
    repeat (49) tick();
    check_eq("nr_no_stb", 32'(stb_cycles), 32'd0);
    check_eq("nr_busy", 32'(busy), 32'd1);
    ready = 1'b1;
    wait_idle(nb);
    check_pass("nr", wbase, 1'b0, nb);

    // Stray acks during gap and idle cycles
    stray_en = 1'b1;
    wbase = wlog_adr.size();
    pulse_start();
    wait_idle(nb);
    check_pass("stray", wbase, 1'b1, nb);
    stray_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_test_master.md
Name: ram_test_master

Overview:
- Bus initiator on the sdram_* word-memory port (stb/we/sel/ack/adr/out/dat/ready), i.e. the requester side of the on-chip RAM responder.
- Runs a power-up self-test of main memory in three phases:
  - write an address-derived pattern to every word;
  - read every word back and verify it;
  - optionally clear memory.
- Sits between the board-level RAM and the topboard memory mux. The processor is held off while busy is high.

Parameters:
- ADR_LAST, 21'h007FFF: last word address tested (word address bits [21:1]). Default covers 64 KB.
- TIMEOUT, 16: maximum cycles from stb assertion to ack before the test fails.
- PAT_KEY, 16'o125252: XOR key used by the pattern function.

Ports:
- clk_p  in  1  processor clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a test when idle.
- busy  out  1  high while a test is running.
- done  out  1  high when the last test passed; held until the next start or reset.
- fail  out  1  high when the last test failed; held until the next start or reset.
- fail_code  out  2  failure reason: 01 data mismatch, 10 ack timeout, 00 none.
- fail_adr  out  21  word address [21:1] of the first failure.
- fail_dat  out  16  data read at the first mismatch; 0 on timeout.
- mem_stb  out  1  transaction strobe.
- mem_we  out  1  1 = write, 0 = read.
- mem_sel  out  2  byte enables; always 2'b11.
- mem_adr  out  21  word address [21:1].
- mem_out  out  16  write data.
- mem_dat  in  16  read data; valid when mem_ack is high.
- mem_ack  in  1  transaction acknowledge.
- mem_ready  in  1  responder ready flag.

Behaviour:
- Reset values:
  - state IDLE.
  - All outputs 0, except mem_sel = 2'b11.
  - Reset mid-test drops mem_stb in the same edge and abandons the test. No partial done/fail is reported.
- Pattern: pat(a) = a[16:1] ^ PAT_KEY. Address bits [21:17] do not enter the pattern.
- States:
  - IDLE
    - start=1 → WAIT_RDY.
    - On entry from start: done, fail, fail_code, fail_adr and fail_dat are cleared, and busy is set.
    - start is ignored in every other state.
  - WAIT_RDY: mem_ready=1 → WR_REQ with addr=0.
  - WR_REQ
    - Drives mem_stb=1, mem_we=1, mem_adr=addr, mem_out=pat(addr).
    - All bus outputs are held stable until ack.
    - On ack → WR_GAP.
  - WR_GAP
    - One cycle with mem_stb=0; mandatory so the responder's ack pipeline clears.
    - If addr==ADR_LAST: addr=0 → RD_REQ. Otherwise addr+1 → WR_REQ.
  - RD_REQ
    - Drives mem_stb=1, mem_we=0.
    - On ack, mem_dat is compared with pat(addr):
      - Mismatch: latch fail_adr=addr, fail_dat=mem_dat, fail_code=01 → FAIL.
      - Match: → RD_GAP.
  - RD_GAP: one idle cycle. If addr==ADR_LAST → CLR_REQ with addr=0 (feature enabled) or DONE. Otherwise addr+1 → RD_REQ.
  - CLR_REQ / CLR_GAP: as WR_REQ/WR_GAP, but with mem_out=16'o000000. At ADR_LAST → DONE.
  - DONE: busy=0, done=1 → IDLE in the same cycle. The done level holds.
  - FAIL: mem_stb=0, busy=0, fail=1 → IDLE.
- Timeout:
  - A counter is cleared on entry to any *_REQ state and increments every cycle while mem_stb=1 and mem_ack=0.
  - When it reaches TIMEOUT: fail_code=10, fail_adr=addr, fail_dat=0 → FAIL.
  - If ack arrives in the same cycle the count reaches TIMEOUT, ack wins.
- Ack handling: mem_ack is honoured only while mem_stb=1; a stray ack in a GAP or in IDLE is ignored.
- mem_ready falling mid-test: the current transaction still completes; the master does not re-check ready after WAIT_RDY.
- Latency against the standard 2-wait responder:
  - 3 cycles per REQ (ack on the 3rd stb cycle) plus 1 GAP cycle = 4 cycles per word per phase.
  - Total = 4·(ADR_LAST+1)·phases + 2.
- Address counter: 21 bits. ADR_LAST=0 is legal (one word per phase). Wrap past 21'h1FFFFF never occurs because termination is by compare.

Optional Feature:
- Macro: RAM_TEST_CLEAR_EN.
- Defined: after a passing read phase, the clear phase zero-fills 0..ADR_LAST before DONE.
- Undefined: CLR states are not compiled; RD_GAP at ADR_LAST goes directly to DONE and memory keeps the pattern.

Decomposition:
- Shared package (or include beside config.v):
  - state encoding constants;
  - fail_code values FC_NONE=2'b00, FC_MISMATCH=2'b01, FC_TIMEOUT=2'b10;
  - the default PAT_KEY;
  - the pat() function.
- One natural sub-module, ram_test_timeout: a loadable down-counter with an expiry flag, reusable by other bus masters.
- The FSM, address counter and comparator stay in ram_test_master.

Test Plan:
- Model the responder as a 64K-word RAM with a 2-cycle ack delay. ADR_LAST=7, start pulse. Expect:
  - writes 0..7 with data 0o125252, 0o125253, …;
  - busy high for 66 cycles (98 with clear);
  - done=1, fail=0.
- Responder corrupts the read of address 5 to 16'o000000 → fail=1, fail_code=01, fail_adr=5, fail_dat=0; no reads of address 6 or 7 are issued.
- Responder never acks the write to address 3 (TIMEOUT=16) → mem_stb high 16 cycles, then fail_code=10, fail_adr=3, busy=0.
- Reset asserted during the read of address 4 → mem_stb=0 the next cycle, busy=done=fail=0; a new start restarts at address 0.
- mem_ready=0 for 50 cycles after start → no mem_stb until ready rises; then normal pass.
- With RAM_TEST_CLEAR_EN defined, after done every RAM word 0..7 reads 0. Stray acks injected in GAP cycles do not advance the address.
